// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg: shared types and default widths for the memory bus arbiter.
// Imported by riscv_arb_watchdog and riscv_bus_arbiter.
package riscv_bus_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IBUS,
    ARB_DBUS,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IBUS,
    OWN_DBUS
  } owner_e;

  function automatic arb_state_e bus_state(owner_e o);
    return (o == OWN_DBUS) ? ARB_DBUS : ARB_IBUS;
  endfunction

endpackage

// File: rtl/riscv_arb_watchdog.sv
// riscv_arb_watchdog: counts unacknowledged bus cycles and flags expiry
// on the TIMEOUT_CYC-th consecutive cycle without ack.
module riscv_arb_watchdog
  import riscv_bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter: shares one memory bus between fetch and data ports.
// Define RISCV_BUS_ARB_RR_EN for round-robin ties (default: data first).
module riscv_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_ibus_req,
  input  logic [ADDR_W-1:0]   i_ibus_addr,
  output logic [DATA_W-1:0]   o_ibus_rdata,
  output logic                o_ibus_valid,
  output logic                o_ibus_err,
  input  logic                i_dbus_req,
  input  logic                i_dbus_we,
  input  logic [DATA_W/8-1:0] i_dbus_be,
  input  logic [ADDR_W-1:0]   i_dbus_addr,
  input  logic [DATA_W-1:0]   i_dbus_wdata,
  output logic [DATA_W-1:0]   o_dbus_rdata,
  output logic                o_dbus_valid,
  output logic                o_dbus_err,
  output logic                o_bus_req,
  output logic                o_bus_we,
  output logic [DATA_W/8-1:0] o_bus_be,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [DATA_W-1:0]   o_bus_wdata,
  input  logic                i_bus_ack,
  input  logic [DATA_W-1:0]   i_bus_rdata,
  output logic                o_stall_if,
  output logic                o_bus_stall_m
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        state_q;
  owner_e            own_q;
  owner_e            win;
  logic              any_req;
  logic              in_bus;
  logic              wd_en;
  logic              wd_exp;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [BE_W-1:0]   bus_be_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] irdata_q;
  logic [DATA_W-1:0] drdata_q;
  logic              ivalid_q;
  logic              dvalid_q;
  logic              ierr_q;
  logic              derr_q;

  assign any_req = i_ibus_req | i_dbus_req;
  assign in_bus  = (state_q == ARB_IBUS) | (state_q == ARB_DBUS);
  assign wd_en   = in_bus & ~i_bus_ack;

`ifdef RISCV_BUS_ARB_RR_EN
  owner_e last_q;

  always_comb begin
    win = i_dbus_req ? OWN_DBUS : OWN_IBUS;
    if (i_ibus_req && i_dbus_req)
      win = (last_q == OWN_DBUS) ? OWN_IBUS : OWN_DBUS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_q <= OWN_DBUS;
    else if (state_q == ARB_IDLE && any_req)
      last_q <= win;
  end
`else
  assign win = i_dbus_req ? OWN_DBUS : OWN_IBUS;
`endif

  riscv_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_q == ARB_IDLE),
    .en_i    (wd_en),
    .expire_o(wd_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      own_q       <= OWN_DBUS;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      ivalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      ierr_q      <= 1'b0;
      derr_q      <= 1'b0;
    end else begin
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      ierr_q   <= 1'b0;
      derr_q   <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            bus_req_q <= 1'b1;
            own_q     <= win;
            state_q   <= bus_state(win);
            if (win == OWN_DBUS) begin
              bus_we_q    <= i_dbus_we;
              bus_be_q    <= i_dbus_be;
              bus_addr_q  <= i_dbus_addr;
              bus_wdata_q <= i_dbus_wdata;
            end else begin
              bus_we_q    <= 1'b0;
              bus_be_q    <= '1;
              bus_addr_q  <= i_ibus_addr;
              bus_wdata_q <= '0;
            end
          end
        end
        ARB_IBUS, ARB_DBUS: begin
          // ack beats expiry: wd_exp is only raised in no-ack cycles
          if (i_bus_ack || wd_exp) begin
            bus_req_q <= 1'b0;
            state_q   <= ARB_RESP;
            if (own_q == OWN_IBUS) begin
              ivalid_q <= 1'b1;
              ierr_q   <= ~i_bus_ack;
              irdata_q <= i_bus_ack ? i_bus_rdata : '0;
            end else begin
              dvalid_q <= 1'b1;
              derr_q   <= ~i_bus_ack;
              if (!i_bus_ack)
                drdata_q <= '0;
              else if (!bus_we_q)
                drdata_q <= i_bus_rdata;
            end
          end
        end
        ARB_RESP: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign o_bus_req     = bus_req_q;
  assign o_bus_we      = bus_we_q;
  assign o_bus_be      = bus_be_q;
  assign o_bus_addr    = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_ibus_rdata  = irdata_q;
  assign o_ibus_valid  = ivalid_q;
  assign o_ibus_err    = ierr_q;
  assign o_dbus_rdata  = drdata_q;
  assign o_dbus_valid  = dvalid_q;
  assign o_dbus_err    = derr_q;
  assign o_stall_if    = i_ibus_req & ~ivalid_q;
  assign o_bus_stall_m = i_dbus_req & ~dvalid_q;

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// tb_riscv_bus_arbiter: random transactions against a transaction-level
// model of grant order, latency, watchdog and response data.
module tb_riscv_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_ibus_req = 1'b0;
  logic [AW-1:0] i_ibus_addr = '0;
  logic [DW-1:0] o_ibus_rdata;
  logic          o_ibus_valid;
  logic          o_ibus_err;
  logic          i_dbus_req = 1'b0;
  logic          i_dbus_we = 1'b0;
  logic [3:0]    i_dbus_be = '0;
  logic [AW-1:0] i_dbus_addr = '0;
  logic [DW-1:0] i_dbus_wdata = '0;
  logic [DW-1:0] o_dbus_rdata;
  logic          o_dbus_valid;
  logic          o_dbus_err;
  logic          o_bus_req;
  logic          o_bus_we;
  logic [3:0]    o_bus_be;
  logic [AW-1:0] o_bus_addr;
  logic [DW-1:0] o_bus_wdata;
  logic          i_bus_ack = 1'b0;
  logic [DW-1:0] i_bus_rdata = '0;
  logic          o_stall_if;
  logic          o_bus_stall_m;

  riscv_bus_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ibus_req   (i_ibus_req),
    .i_ibus_addr  (i_ibus_addr),
    .o_ibus_rdata (o_ibus_rdata),
    .o_ibus_valid (o_ibus_valid),
    .o_ibus_err   (o_ibus_err),
    .i_dbus_req   (i_dbus_req),
    .i_dbus_we    (i_dbus_we),
    .i_dbus_be    (i_dbus_be),
    .i_dbus_addr  (i_dbus_addr),
    .i_dbus_wdata (i_dbus_wdata),
    .o_dbus_rdata (o_dbus_rdata),
    .o_dbus_valid (o_dbus_valid),
    .o_dbus_err   (o_dbus_err),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_be     (o_bus_be),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_ack    (i_bus_ack),
    .i_bus_rdata  (i_bus_rdata),
    .o_stall_if   (o_stall_if),
    .o_bus_stall_m(o_bus_stall_m)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  bit          ip, dp, dwe;
  logic [31:0] ia, dad, dwd;
  logic [3:0]  dbe;
  logic [31:0] m_ir, m_dr;
  bit          m_last_d;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    i_ibus_req   = ip;
    i_ibus_addr  = ia;
    i_dbus_req   = dp;
    i_dbus_we    = dwe;
    i_dbus_be    = dbe;
    i_dbus_addr  = dad;
    i_dbus_wdata = dwd;
  endtask

  function automatic bit pick_d();
    bit w;
    w = dp;
`ifdef RISCV_BUS_ARB_RR_EN
    if (ip && dp) w = !m_last_d;
`endif
    return w;
  endfunction

  // d: cycles without ack before ack; d >= TMO means never acked
  task automatic step(input int d, input logic [31:0] rd);
    bit w, to, done;
    int k;
    @(negedge clk);
    drive();
    i_bus_ack = 1'b0;
    w = pick_d();
    m_last_d = w;
    @(posedge clk); #1;
    chk("grant_req", o_bus_req, 1);
    chk("grant_addr", o_bus_addr, w ? dad : ia);
    chk("grant_we", o_bus_we, w ? dwe : 1'b0);
    chk("grant_be", o_bus_be, w ? dbe : 4'hF);
    if (w) chk("grant_wdata", o_bus_wdata, dwd);
    to = (d >= TMO);
    done = 0;
    k = 0;
    while (!done) begin
      @(negedge clk);
      i_bus_ack = (k == d);
      i_bus_rdata = (k == d) ? rd : $urandom;
      @(posedge clk); #1;
      if (k == d || k == TMO - 1) begin
        done = 1;
      end else begin
        chk("hold_req", o_bus_req, 1);
        chk("hold_quiet",
            {o_ibus_valid, o_dbus_valid, o_ibus_err, o_dbus_err}, 0);
        chk("hold_stall", {o_stall_if, o_bus_stall_m}, {ip, dp});
      end
      k++;
    end
    if (to) begin
      if (w) m_dr = '0;
      else   m_ir = '0;
    end else if (!w) begin
      m_ir = rd;
    end else if (!dwe) begin
      m_dr = rd;
    end
    chk("resp_valid", {o_ibus_valid, o_dbus_valid}, w ? 2'b01 : 2'b10);
    chk("resp_err", {o_ibus_err, o_dbus_err},
        to ? (w ? 2'b01 : 2'b10) : 2'b00);
    chk("resp_irdata", o_ibus_rdata, m_ir);
    chk("resp_drdata", o_dbus_rdata, m_dr);
    chk("resp_req", o_bus_req, 0);
    chk("resp_stall_if", o_stall_if, ip & w);
    chk("resp_stall_m", o_bus_stall_m, dp & !w);
    @(negedge clk);
    if (w) dp = 0;
    else   ip = 0;
    drive();
    i_bus_ack = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("after_resp",
        {o_bus_req, o_ibus_valid, o_dbus_valid, o_ibus_err, o_dbus_err}, 0);
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      drive();
      i_bus_ack = 1'($urandom_range(0, 1));
      i_bus_rdata = $urandom;
      @(posedge clk); #1;
      chk("idle_stray", {o_bus_req, o_ibus_valid, o_dbus_valid}, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1);
  end

  initial begin
    int r, d;
    ip = 0; dp = 0; dwe = 0;
    ia = '0; dad = '0; dwd = '0; dbe = '0;
    m_ir = '0; m_dr = '0; m_last_d = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {o_bus_req, o_bus_we, o_ibus_valid, o_dbus_valid,
                    o_ibus_err, o_dbus_err}, 0);
    chk("rst_addr", o_bus_addr, 0);
    chk("rst_wdata", o_bus_wdata, 0);
    chk("rst_be", o_bus_be, 0);
    chk("rst_rdata", {o_ibus_rdata, o_dbus_rdata}, 0);
    @(negedge clk) rst_n = 1'b1;
    idle_cyc(2);

    ip = 1; ia = 32'h100;
    step(3, 32'hDEAD_BEEF);

    ip = 1; ia = 32'h104;
    dp = 1; dwe = 1; dad = 32'h2000; dwd = 32'h1234_5678; dbe = 4'h3;
    step(1, 32'h5555_AAAA);
    step(0, 32'h0BAD_F00D);

    dp = 1; dwe = 0; dad = 32'h3000; dbe = 4'hF;
    step(TMO, 32'hFFFF_FFFF);
    dp = 1; dwe = 0; dad = 32'h3004;
    step(TMO - 1, 32'hCAFE_F00D);

    repeat (4) begin
      if (!ip) begin ip = 1; ia = ia + 32'h4; end
      if (!dp) begin dp = 1; dwe = 0; dad = dad + 32'h4; end
      step(0, $urandom);
    end
    ip = 0; dp = 0;
    if (o_stall_if === 1'b1) ip = 1;
    while (ip || dp) step(0, $urandom);

    dp = 1; dwe = 0; dad = 32'h4000; dbe = 4'hF;
    @(negedge clk);
    drive();
    i_bus_ack = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_req", o_bus_req, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    dp = 0;
    drive();
    @(posedge clk); #1;
    chk("rst_mid", {o_bus_req, o_ibus_valid, o_dbus_valid,
                    o_ibus_err, o_dbus_err}, 0);
    chk("rst_mid_rdata", {o_ibus_rdata, o_dbus_rdata}, 0);
    m_ir = '0; m_dr = '0; m_last_d = 1;
    @(negedge clk) rst_n = 1'b1;
    idle_cyc(3);

    repeat (150) begin
      if (!ip && !dp && $urandom_range(0, 3) == 0)
        idle_cyc($urandom_range(1, 3));
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ia = $urandom;
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1;
        dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom);
        dad = $urandom;
        dwd = $urandom;
      end
      if (!ip && !dp) begin
        ip = 1; ia = $urandom;
      end
      r = $urandom_range(0, 19);
      d = (r == 0) ? TMO + $urandom_range(0, 3) :
          (r == 1) ? TMO - 1 : $urandom_range(0, 4);
      step(d, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_bus_arbiter.md
# riscv_bus_arbiter

Shares the single external memory bus between the fetch stage (instruction port) and the memory stage (data port) of the 5-stage core. Arbitrates one outstanding transaction at a time, registers the winning request onto the bus, returns response data, and emits the fetch-stall and memory-stall signals consumed by the pipeline hazard unit. A watchdog terminates bus transactions that are never acknowledged.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- TIMEOUT_CYC, 64, cycles in a bus state without ack before error termination (must be ≥ 2)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset rst_n, synchronous, active-low
- i_ibus_req  in  1  fetch request; held with i_ibus_addr until o_ibus_valid
- i_ibus_addr  in  ADDR_W  fetch address
- o_ibus_rdata  out  DATA_W  fetch data, valid with o_ibus_valid
- o_ibus_valid  out  1  one-cycle completion pulse
- o_ibus_err  out  1  qualifies o_ibus_valid: timeout
- i_dbus_req  in  1  data request; payload held until o_dbus_valid
- i_dbus_we  in  1  1 = store
- i_dbus_be  in  DATA_W/8  byte enables
- i_dbus_addr  in  ADDR_W  data address
- i_dbus_wdata  in  DATA_W  store data
- o_dbus_rdata  out  DATA_W  load data
- o_dbus_valid  out  1  one-cycle completion pulse
- o_dbus_err  out  1  qualifies o_dbus_valid: timeout
- o_bus_req  out  1  registered bus request
- o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered payload; be = all ones and we = 0 for fetch
- i_bus_ack  in  1  slave accepts/completes in this cycle
- i_bus_rdata  in  DATA_W  read data, valid with i_bus_ack
- o_stall_if  out  1  combinational: i_ibus_req & ~o_ibus_valid
- o_bus_stall_m  out  1  combinational: i_dbus_req & ~o_dbus_valid; drives hazard unit bus-stall input

## Operation
- States: ARB_IDLE, ARB_IBUS, ARB_DBUS, ARB_RESP.
- ARB_IDLE: no request -> stay. Otherwise select winner, latch its payload into o_bus_*, set o_bus_req, go to ARB_IBUS/ARB_DBUS.
- Default priority: data beats fetch (memory stage freezes older instruction; avoids deadlock).
- ARB_IBUS/ARB_DBUS: o_bus_req held, payload stable. On i_bus_ack: capture i_bus_rdata to the owner's rdata, clear o_bus_req, go to ARB_RESP. Stores also return through ARB_RESP (rdata undefined, keep previous).
- Watchdog: counter cleared on entry to bus state, increments each cycle without ack; at TIMEOUT_CYC-1 with no ack: clear o_bus_req, owner rdata = 0, set owner err, go to ARB_RESP. Ack in the same cycle wins (no error).
- ARB_RESP: owner's valid = 1 (err as latched) for exactly this cycle; no new grant; -> ARB_IDLE. Requester may drop or change req in the cycle after valid.
- i_bus_ack in ARB_IDLE/ARB_RESP: ignored.
- Request dropped while granted: illegal; transaction still completes and pulses valid.

## Timing
- Reset: state ARB_IDLE; o_bus_req, o_bus_we, o_*_valid, o_*_err = 0; o_bus_addr/wdata/be, rdata = 0; counter 0; last-grant = data.
- Reset mid-transaction: o_bus_req low on the next edge; no valid pulse.
- Req seen in IDLE at edge n -> o_bus_req high after edge n; ack at edge m (m > n) -> valid high cycle after edge m; back to IDLE one cycle later. Minimum request-to-valid: 2 cycles, minimum request-to-next-accept: 3 cycles.
- Both requests in IDLE simultaneously: one granted; loser stalls until next IDLE.

## Configuration
- RISCV_BUS_ARB_RR_EN defined: round-robin — on simultaneous requests grant the port not granted last; last-grant register updates on every grant, resets to data (first tie -> fetch).
- Undefined: fixed data-over-fetch priority; last-grant register absent.

## Structure
- Package riscv_bus_pkg: arb_state_e, owner enum (OWN_IBUS, OWN_DBUS), default width localparams.
- Sub-module riscv_arb_watchdog: clear/enable inputs, expire output, width $clog2(TIMEOUT_CYC).

## Test plan
- Single fetch to 0x100, ack after 3 cycles with 0xDEADBEEF -> o_bus_we=0, be=4'hF, o_ibus_rdata=0xDEADBEEF, one-cycle o_ibus_valid, o_stall_if low that cycle.
- Fetch and store (0x2000, 0x1234_5678, be=4'h3) in same cycle, fixed priority -> store issued first, fetch issued after store's ARB_RESP; o_stall_if high throughout.
- With RISCV_BUS_ARB_RR_EN, both ports requesting continuously, 1-cycle acks -> grants alternate fetch, data, fetch, data.
- No ack for TIMEOUT_CYC=64 on load -> o_bus_req drops, o_dbus_valid and o_dbus_err pulse, rdata 0; ack arriving exactly at cycle 64 -> normal completion, err 0.
- rst_n low while in ARB_DBUS -> next edge o_bus_req=0, state IDLE, no valid pulse; stray ack in IDLE ignored.
